// File: rtl/gbe_txpacketbuffer.sv
// GbE transmit packet buffer: a circular byte RAM filled by the IPbus packet
// builder, a FIFO of committed lengths, and a MAC-side streamer with ack + IFG.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   packet_txd/txa/txwe  user byte write, address relative to packet start
//   packet_len/txdone    commit length, commit on txdone rising edge
//   packet_txready       room for one more 2047-byte packet
//   packet_txdrop        one-cycle pulse on a rejected commit
//   mac_txd/txdv/txack   MAC transmit stream; txack accepts byte 0
// Build option: GBE_TX_MINPAD_EN pads frames shorter than 60 bytes with 0x00.
module gbe_txpacketbuffer #(
  parameter int BUF_AW         = 12,
  parameter int LEN_DEPTH_LOG2 = 2,
  parameter int IFG_CYCLES     = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  packet_txd,
  input  logic [10:0] packet_txa,
  input  logic        packet_txwe,
  input  logic [10:0] packet_len,
  input  logic        packet_txdone,
  output logic        packet_txready,
  output logic        packet_txdrop,
  output logic [7:0]  mac_txd,
  output logic        mac_txdv,
  input  logic        mac_txack
);

  localparam int DEPTH = 1 << LEN_DEPTH_LOG2;
  localparam int CW    = LEN_DEPTH_LOG2 + 1;
  localparam int GW    = $clog2(IFG_CYCLES + 1);
  localparam logic [BUF_AW:0] BUF_SIZE = {1'b1, {BUF_AW{1'b0}}};
  localparam logic [BUF_AW:0] MAX_PKT  = (BUF_AW + 1)'(2048);

  typedef logic [BUF_AW-1:0] addr_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_ACK,
    SEND,
    GAP
  } state_t;

  logic [7:0]  ram [2**BUF_AW];
  logic [7:0]  rd_data;
  logic [10:0] len_fifo [DEPTH];

  addr_t write_base, read_base;
  addr_t wb_n, rb_n, rd_addr;
  logic [LEN_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, cnt_n;
  logic [BUF_AW:0] used_n, free_n;

  state_t state, state_n;
  logic [10:0] len, idx, idx_n, frame_len;
  logic [GW-1:0] gap_cnt;

  logic done_d, commit, push, pop, load_len;

  assign commit = packet_txdone & ~done_d;
  assign push   = commit & packet_txready & (packet_len != 11'd0);

`ifdef GBE_TX_MINPAD_EN
  assign frame_len = (len < 11'd60) ? 11'd60 : len;
`else
  assign frame_len = len;
`endif

  always_comb begin
    state_n  = state;
    idx_n    = '0;
    pop      = 1'b0;
    load_len = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          state_n  = LOAD;
          load_len = 1'b1;
        end
      end
      LOAD: state_n = WAIT_ACK;
      WAIT_ACK: begin
        if (mac_txack) begin
          if (frame_len == 11'd1) begin
            state_n = GAP;
            pop     = 1'b1;
          end else begin
            state_n = SEND;
            idx_n   = 11'd1;
          end
        end
      end
      SEND: begin
        if (idx == frame_len - 11'd1) begin
          state_n = GAP;
          pop     = 1'b1;
        end else begin
          idx_n = idx + 11'd1;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // read address runs one byte ahead so rd_data tracks idx each cycle
  assign rd_addr = read_base + addr_t'(idx_n);

  assign wb_n   = write_base + (push ? addr_t'(packet_len) : addr_t'(0));
  assign rb_n   = read_base + (pop ? addr_t'(len) : addr_t'(0));
  assign cnt_n  = count + CW'(push) - CW'(pop);
  assign used_n = {1'b0, wb_n - rb_n};
  assign free_n = BUF_SIZE - used_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      len            <= '0;
      gap_cnt        <= '0;
      write_base     <= '0;
      read_base      <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      done_d         <= 1'b0;
      packet_txready <= 1'b0;
      packet_txdrop  <= 1'b0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      write_base     <= wb_n;
      read_base      <= rb_n;
      count          <= cnt_n;
      done_d         <= packet_txdone;
      packet_txready <= (cnt_n < CW'(DEPTH)) && (free_n >= MAX_PKT);
      packet_txdrop  <= commit & ~push;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (load_len) len <= len_fifo[rd_ptr];
      if (state_n == GAP && state != GAP)
        gap_cnt <= GW'(IFG_CYCLES - 1);
      else if (gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) len_fifo[wr_ptr] <= packet_len;
  end

  always_ff @(posedge clk) begin
    if (packet_txwe && packet_txready)
      ram[write_base + addr_t'(packet_txa)] <= packet_txd;
    rd_data <= ram[rd_addr];
  end

  assign mac_txdv = (state == WAIT_ACK) || (state == SEND);

`ifdef GBE_TX_MINPAD_EN
  assign mac_txd = (mac_txdv && idx < len) ? rd_data : 8'h00;
`else
  assign mac_txd = mac_txdv ? rd_data : 8'h00;
`endif

endmodule

// File: tb/tb_gbe_txpacketbuffer.sv
// Scoreboard bench for gbe_txpacketbuffer: stimulus pushes expected frames,
// a negedge monitor pops and compares every presented byte, length and gap.
module tb_gbe_txpacketbuffer;

  localparam int IFG = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  packet_txd = '0;
  logic [10:0] packet_txa = '0;
  logic        packet_txwe = 1'b0;
  logic [10:0] packet_len = '0;
  logic        packet_txdone = 1'b0;
  logic        packet_txready;
  logic        packet_txdrop;
  logic [7:0]  mac_txd;
  logic        mac_txdv;
  logic        mac_txack = 1'b0;

  always #5 clk = ~clk;

  gbe_txpacketbuffer #(
    .BUF_AW(12),
    .LEN_DEPTH_LOG2(2),
    .IFG_CYCLES(IFG)
  ) dut (
    .clk(clk),
    .reset(reset),
    .packet_txd(packet_txd),
    .packet_txa(packet_txa),
    .packet_txwe(packet_txwe),
    .packet_len(packet_len),
    .packet_txdone(packet_txdone),
    .packet_txready(packet_txready),
    .packet_txdrop(packet_txdrop),
    .mac_txd(mac_txd),
    .mac_txdv(mac_txdv),
    .mac_txack(mac_txack)
  );

  int checks = 0;
  int passes = 0;

  logic [7:0] mem [4096];
  int wb = 0;
  logic [7:0] byte_q [$];
  int len_q [$];

  int mon_n = 0;
  bit acked = 0;
  bit prev_dv = 0;
  bit gap_armed = 0;
  int gap = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_rng(string name, int act, int lo, int hi);
    checks++;
    if (act >= lo && act <= hi) passes++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      byte_q.delete();
      len_q.delete();
      mon_n = 0;
      acked = 0;
      prev_dv = 0;
      gap_armed = 0;
    end else begin
      if (mac_txdv) begin
        if (!prev_dv && gap_armed) begin
          chk_rng("ifg", gap, IFG, IFG + 2);
          gap_armed = 0;
        end
        if (byte_q.size() == 0) chk("txdv_unexpected", mac_txdv, 0);
        else if (!acked && !mac_txack) chk("txd_hold", mac_txd, byte_q[0]);
        else begin
          chk("txd", mac_txd, byte_q.pop_front());
          acked = 1;
          mon_n++;
        end
      end else begin
        if (prev_dv) begin
          chk("txd_idle", mac_txd, 0);
          if (len_q.size() > 0) begin
            chk("frame_len", mon_n, len_q.pop_front());
            gap_armed = (len_q.size() > 0);
          end
          gap = 1;
        end else gap++;
        mon_n = 0;
        acked = 0;
      end
      prev_dv = mac_txdv;
    end
  end

  task automatic write_pkt(int len, int seed, int step);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      packet_txwe = 1'b1;
      packet_txa  = 11'(i);
      packet_txd  = 8'(seed + i * step);
      mem[(wb + i) % 4096] = 8'(seed + i * step);
    end
    @(posedge clk); #1;
    packet_txwe = 1'b0;
  endtask

  task automatic commit(int len, bit ok, bit exp_rdy);
    int flen;
    @(posedge clk); #1;
    packet_len    = 11'(len);
    packet_txdone = 1'b1;
    @(posedge clk); #1;
    packet_txdone = 1'b0;
    chk("drop", packet_txdrop, ok ? 0 : 1);
    chk("ready", packet_txready, exp_rdy);
    if (ok) begin
      flen = len;
      for (int i = 0; i < len; i++) byte_q.push_back(mem[(wb + i) % 4096]);
`ifdef GBE_TX_MINPAD_EN
      for (int i = len; i < 60; i++) byte_q.push_back(8'h00);
      if (len < 60) flen = 60;
`endif
      len_q.push_back(flen);
      wb = (wb + len) % 4096;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(posedge clk); #1;
      if (byte_q.size() == 0 && len_q.size() == 0 && !mac_txdv) done = 1;
    end
    chk("drain", int'(done), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bit hit;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", packet_txready, 0);
    chk("rst_txdv", mac_txdv, 0);
    chk("rst_txd", mac_txd, 0);
    chk("rst_drop", packet_txdrop, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", packet_txready, 1);

    // 64-byte frame, ack held high
    mac_txack = 1'b1;
    write_pkt(64, 0, 1);
    commit(64, 1, 1);
    wait_idle();
    chk("ready_t1", packet_txready, 1);

    // fill the length FIFO with ack low, fifth commit rejected
    mac_txack = 1'b0;
    write_pkt(100, 3, 7);
    commit(100, 1, 1);
    write_pkt(200, 11, 3);
    commit(200, 1, 1);
    write_pkt(300, 29, 5);
    commit(300, 1, 1);
    write_pkt(400, 77, 13);
    commit(400, 1, 0);
    commit(50, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    mac_txack = 1'b1;
    wait_idle();
    chk("ready_t2", packet_txready, 1);

    // advance write_base to 4000, then a frame straddling the wrap
    write_pkt(1468, 1, 1);
    commit(1468, 1, 1);
    wait_idle();
    write_pkt(1468, 91, 3);
    commit(1468, 1, 1);
    wait_idle();
    chk("wb_model", wb, 4000);
    write_pkt(200, 200, 1);
    commit(200, 1, 1);
    wait_idle();

    // byte 0 held for 20 cycles in WAIT_ACK, then released
    mac_txack = 1'b0;
    write_pkt(20, 80, 5);
    commit(20, 1, 1);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk); #1;
      if (mac_txdv) hit = 1;
    end
    chk("wait_ack_reached", int'(hit), 1);
    repeat (20) @(posedge clk);
    #1;
    mac_txack = 1'b1;
    wait_idle();

    // zero-length commit dropped, no frame
    commit(0, 0, 1);
    repeat (20) @(posedge clk);

    // reset at byte 30 of a 100-byte frame with two more queued
    mac_txack = 1'b0;
    write_pkt(100, 5, 9);
    commit(100, 1, 1);
    write_pkt(50, 17, 1);
    commit(50, 1, 1);
    write_pkt(50, 33, 1);
    commit(50, 1, 1);
    @(posedge clk); #1;
    mac_txack = 1'b1;
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(posedge clk);
      if (mon_n >= 30) hit = 1;
    end
    chk("reached_byte30", int'(hit), 1);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_txdv", mac_txdv, 0);
    chk("rst_mid_txd", mac_txd, 0);
    reset = 1'b0;
    wb = 0;
    @(posedge clk); #1;
    chk("rst_mid_ready", packet_txready, 1);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (mac_txdv) seen++;
    end
    chk("no_frame_after_rst", seen, 0);

    // short frame: padded to 60 only in the padding build
    write_pkt(10, 8'hAA, 0);
    commit(10, 1, 1);
    wait_idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
